// File: rtl/sdram_master_arbiter_pkg.sv
// Shared definitions for the SDRAM master arbiter and the move-generator
// engines that sit on its request side.
//   - BUS_NUM_REQ / BUS_AW / BUS_DW : default engine count and bus widths
//   - arb_state_t                   : arbiter FSM state encoding
package sdram_master_arbiter_pkg;

    localparam int BUS_NUM_REQ = 4;
    localparam int BUS_AW      = 32;
    localparam int BUS_DW      = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RD = 2'd1,
        RD_DATA  = 2'd2,
        GRANT_WR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sdram_master_arbiter_if.sv
// Bundle of the engine-side (req_*) and SDRAM-side (master_*) Avalon-MM
// signals around the arbiter.
//   modport master : the arbiter's view (receives engine strobes, drives the
//                    SDRAM port and the per-engine stall/read-data returns)
//   modport slave  : the environment's view (engines plus SDRAM interconnect)
// Engine i occupies req_address[i*AW +: AW] and req_writedata[i*DW +: DW].
interface sdram_master_arbiter_if
    import sdram_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = BUS_NUM_REQ,
    parameter int AW      = BUS_AW,
    parameter int DW      = BUS_DW
) ();

    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_address;
    logic [NUM_REQ*DW-1:0] req_writedata;
    logic [NUM_REQ-1:0]    req_waitrequest;
    logic [DW-1:0]         req_readdata;
    logic [NUM_REQ-1:0]    req_readdatavalid;

    logic                  master_waitrequest;
    logic [AW-1:0]         master_address;
    logic                  master_read;
    logic                  master_write;
    logic [DW-1:0]         master_writedata;
    logic [DW-1:0]         master_readdata;
    logic                  master_readdatavalid;

    modport master (
        input  req_read, req_write, req_address, req_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output master_address, master_read, master_write, master_writedata
    );

    modport slave (
        output req_read, req_write, req_address, req_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  master_address, master_read, master_write, master_writedata
    );

endinterface

// File: rtl/sdram_master_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   pending : one bit per requester
//   rr_ptr  : index where the search starts
//   found   : at least one pending bit is set
//   index   : first pending requester at or after rr_ptr, wrapping
//             NUM_REQ-1 -> 0
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      index
);

    localparam logic [IW:0] NUM_W = (IW+1)'(NUM_REQ);

    // cand[k] is the requester examined at search offset k from rr_ptr.
    logic [IW-1:0]      cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IW:0] sum;
            // rr_ptr < NUM_REQ, so one conditional subtract is a full modulo.
            assign sum      = {1'b0, rr_ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum >= NUM_W) ? IW'(sum - NUM_W) : sum[IW-1:0];
            assign hit[gi]  = pending[cand[gi]];
        end
    endgenerate

    // Walk from the far end so the smallest offset wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/sdram_master_arbiter.sv
// Shares one Avalon-MM SDRAM master port among NUM_REQ engine masters.
// Round-robin grant, one transaction outstanding system-wide.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : engine-side req_* signals and SDRAM-side master_* signals
// The granted engine's address/writedata pass straight through while in a
// GRANT state; elsewhere the SDRAM port holds the last forwarded value.
module sdram_master_arbiter
    import sdram_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = BUS_NUM_REQ,
    parameter int AW      = BUS_AW,
    parameter int DW      = BUS_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sdram_master_arbiter_if.master bus
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_t         state_reg, state_next;
    logic [IW-1:0]      owner_reg, owner_next;
    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [AW-1:0]      addr_hold_reg;
    logic [DW-1:0]      wdata_hold_reg;

    logic [NUM_REQ-1:0] pending;
    logic               pick_found;
    logic [IW-1:0]      pick_index;
    logic [IW-1:0]      owner_plus_one;
    logic               granted;

    logic [AW-1:0]      addr_arr  [NUM_REQ];
    logic [DW-1:0]      wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = bus.req_address[gi*AW +: AW];
            assign wdata_arr[gi] = bus.req_writedata[gi*DW +: DW];
            // Stall lifts only in the cycle the SDRAM accepts the owner's strobe.
            assign bus.req_waitrequest[gi] =
                ~(granted && (owner_reg == IW'(gi)) && ~bus.master_waitrequest);
            // SDRAM read data is forwarded only while a read is outstanding.
            assign bus.req_readdatavalid[gi] =
                (state_reg == RD_DATA) && bus.master_readdatavalid &&
                (owner_reg == IW'(gi));
        end
    endgenerate

    assign pending            = bus.req_read | bus.req_write;
    assign granted            = (state_reg == GRANT_RD) || (state_reg == GRANT_WR);
    assign owner_plus_one     = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
    assign bus.req_readdata   = bus.master_readdata;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr_reg),
        .found   (pick_found),
        .index   (pick_index)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            rr_ptr_reg     <= '0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            if (granted) begin
                addr_hold_reg  <= addr_arr[owner_reg];
                wdata_hold_reg <= wdata_arr[owner_reg];
            end
        end
    end

    always_comb begin
        state_next           = state_reg;
        owner_next           = owner_reg;
        rr_ptr_next          = rr_ptr_reg;
        bus.master_read      = 1'b0;
        bus.master_write     = 1'b0;
        bus.master_address   = addr_hold_reg;
        bus.master_writedata = wdata_hold_reg;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    owner_next = pick_index;
                    state_next = bus.req_read[pick_index] ? GRANT_RD : GRANT_WR;
                end
            end
            GRANT_RD: begin
                bus.master_read      = 1'b1;
                bus.master_address   = addr_arr[owner_reg];
                bus.master_writedata = wdata_arr[owner_reg];
                // The strobe was on the bus this cycle, so acceptance wins
                // over a simultaneous withdrawal.
                if (!bus.master_waitrequest) begin
                    state_next = RD_DATA;
                end else if (!bus.req_read[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            RD_DATA: begin
                if (bus.master_readdatavalid) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_plus_one;
                end
            end
            GRANT_WR: begin
                bus.master_write     = 1'b1;
                bus.master_address   = addr_arr[owner_reg];
                bus.master_writedata = wdata_arr[owner_reg];
                if (!bus.master_waitrequest) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_plus_one;
                end else if (!bus.req_write[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed, table-driven bench for sdram_master_arbiter (4 engines, 32-bit).
// Each table row is one clock cycle: inputs are driven on the falling edge and
// the combinational outputs are compared shortly after, before the next
// rising edge. Engine i always presents address 0x100+0x10*i and write data
// 0xD0+i; rows only switch strobes, so expected address/data are named by
// the engine whose values should appear (4 = reset value zero).
module tb_sdram_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int ZERO_ID = 4;

    typedef struct {
        logic        rst_n;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        mwait;
        logic        mrdv;
        logic [31:0] mrdata;
        logic        emrd;
        logic        emwr;
        int          eown;
        logic [3:0]  ewait;
        logic [3:0]  erdv;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    vec_t vecs[$];

    sdram_master_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

    sdram_master_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int id);
        return (id == ZERO_ID) ? 32'h0 : 32'h100 + 32'h10 * 32'(id);
    endfunction

    function automatic logic [31:0] wdata_of(input int id);
        return (id == ZERO_ID) ? 32'h0 : 32'hD0 + 32'(id);
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] rd, input logic [3:0] wr,
                                input logic mwait, input logic mrdv, input logic [31:0] mrdata,
                                input logic emrd, input logic emwr, input int eown,
                                input logic [3:0] ewait, input logic [3:0] erdv);
        vec_t v;
        v.rst_n = r;     v.rd = rd;       v.wr = wr;
        v.mwait = mwait; v.mrdv = mrdv;   v.mrdata = mrdata;
        v.emrd = emrd;   v.emwr = emwr;   v.eown = eown;
        v.ewait = ewait; v.erdv = erdv;
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t v);
        logic ok;
        n_vec++;
        ok = (bus.master_read === v.emrd) && (bus.master_write === v.emwr) &&
             (bus.master_address === addr_of(v.eown)) &&
             (bus.master_writedata === wdata_of(v.eown)) &&
             (bus.req_waitrequest === v.ewait) &&
             (bus.req_readdatavalid === v.erdv) &&
             (bus.req_readdata === v.mrdata);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got rd=%b wr=%b addr=%h wdata=%h wait=%b rdv=%b rdata=%h, want rd=%b wr=%b addr=%h wdata=%h wait=%b rdv=%b rdata=%h",
                     name, bus.master_read, bus.master_write, bus.master_address,
                     bus.master_writedata, bus.req_waitrequest, bus.req_readdatavalid,
                     bus.req_readdata, v.emrd, v.emwr, addr_of(v.eown), wdata_of(v.eown),
                     v.ewait, v.erdv, v.mrdata);
        end else begin
            $display("vec %s: rd=%b wr=%b addr=%h wait=%b rdv=%b ok", name,
                     bus.master_read, bus.master_write, bus.master_address,
                     bus.req_waitrequest, bus.req_readdatavalid);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n                    = v.rst_n;
        bus.req_read             = v.rd;
        bus.req_write            = v.wr;
        bus.master_waitrequest   = v.mwait;
        bus.master_readdatavalid = v.mrdv;
        bus.master_readdata      = v.mrdata;
    endtask

    initial begin
        int   cycles;
        vec_t v;

        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_address[i*AW +: AW]   = addr_of(i);
            bus.req_writedata[i*DW +: DW] = wdata_of(i);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO_ID, 4'hF, 0));
        repeat (2) @(negedge clk);

        // Reset state (requests present but reset still held)
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0,      0, 0, ZERO_ID, 4'hF, 0));
        // Single read by engine 0, data 0xAB two cycles after acceptance
        vecs.push_back(mk(1, 4'h1, 0, 1, 0, 0,      0, 0, ZERO_ID, 4'hF, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 0,      1, 0, 0, 4'hE, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,      0, 0, 0, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 1, 32'hAB, 0, 0, 0, 4'hF, 4'h1));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,      0, 0, 0, 4'hF, 0));
        // Reset from IDLE, then all four engines write at once
        vecs.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'hF, 0, 0, 0, 0, 0, ZERO_ID, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, 4'hE, 0));
        vecs.push_back(mk(1, 0, 4'hE, 0, 0, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'hE, 0, 0, 0, 0, 1, 1, 4'hD, 0));
        vecs.push_back(mk(1, 0, 4'hC, 0, 0, 0, 0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'hC, 0, 0, 0, 0, 1, 2, 4'hB, 0));
        vecs.push_back(mk(1, 0, 4'h8, 0, 0, 0, 0, 0, 2, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'h8, 0, 0, 0, 0, 1, 3, 4'h7, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 0, 3, 4'hF, 0));
        // Engine 2 write held off by SDRAM for 5 cycles
        vecs.push_back(mk(1, 0, 4'h4, 1, 0, 0, 0, 0, 3, 4'hF, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 4'h4, 1, 0, 0, 0, 1, 2, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'h4, 0, 0, 0, 0, 1, 2, 4'hB, 0));
        // Wrap: rr_ptr=3, engines 1 and 3 pending; then probe rr_ptr=2
        vecs.push_back(mk(1, 0, 4'hA, 0, 0, 0, 0, 0, 2, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'hA, 0, 0, 0, 0, 1, 3, 4'h7, 0));
        vecs.push_back(mk(1, 0, 4'h2, 0, 0, 0, 0, 0, 3, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'h2, 0, 0, 0, 0, 1, 1, 4'hD, 0));
        vecs.push_back(mk(1, 0, 4'h9, 0, 0, 0, 0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'h9, 0, 0, 0, 0, 1, 3, 4'h7, 0));
        vecs.push_back(mk(1, 0, 4'h1, 0, 0, 0, 0, 0, 3, 4'hF, 0));
        vecs.push_back(mk(1, 0, 4'h1, 0, 0, 0, 0, 1, 0, 4'hE, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'hF, 0));
        // Engine 1 read and write together: read first, write on a later grant
        vecs.push_back(mk(1, 4'h2, 4'h2, 0, 0, 0,      0, 0, 0, 4'hF, 0));
        vecs.push_back(mk(1, 4'h2, 4'h2, 0, 0, 0,      1, 0, 1, 4'hD, 0));
        vecs.push_back(mk(1, 4'h0, 4'h2, 0, 0, 0,      0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 4'h2, 0, 1, 32'h55, 0, 0, 1, 4'hF, 4'h2));
        vecs.push_back(mk(1, 4'h0, 4'h2, 0, 0, 0,      0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 4'h2, 0, 0, 0,      0, 1, 1, 4'hD, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0,      0, 0, 1, 4'hF, 0));
        // Engine 2 withdraws its read while stalled; stray readdatavalid in IDLE
        vecs.push_back(mk(1, 4'h4, 0, 1, 0, 0,      0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 4'h4, 0, 1, 0, 0,      1, 0, 2, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 0, 1, 0, 0,      1, 0, 2, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 1, 32'h33, 0, 0, 2, 4'hF, 0));
        // Reset while engine 3 waits in RD_DATA; late data dropped; restart at rr_ptr=0
        vecs.push_back(mk(1, 4'h8, 0, 0, 0, 0,      0, 0, 2, 4'hF, 0));
        vecs.push_back(mk(1, 4'h8, 0, 0, 0, 0,      1, 0, 3, 4'h7, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0,      0, 0, 3, 4'hF, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 1, 32'h77, 0, 0, ZERO_ID, 4'hF, 0));
        vecs.push_back(mk(1, 4'hA, 0, 0, 0, 0,      0, 0, ZERO_ID, 4'hF, 0));
        vecs.push_back(mk(1, 4'hA, 0, 0, 0, 0,      1, 0, 1, 4'hD, 0));
        vecs.push_back(mk(1, 4'h8, 0, 0, 1, 32'h99, 0, 0, 1, 4'hF, 4'h2));
        vecs.push_back(mk(1, 4'h8, 0, 0, 0, 0,      0, 0, 1, 4'hF, 0));
        vecs.push_back(mk(1, 4'h8, 0, 0, 0, 0,      1, 0, 3, 4'h7, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 1, 32'h12, 0, 0, 3, 4'hF, 4'h8));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,      0, 0, 3, 4'hF, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k]);
            #2;
            check_vec($sformatf("t%0d", k), vecs[k]);
        end

        // Write latency: strobe seen in IDLE at cycle N is accepted at N+1.
        v = mk(1, 4'h0, 4'h4, 0, 0, 0, 0, 0, 3, 4'hF, 0);
        @(negedge clk);
        drive(v);
        #2;
        cycles = 0;
        while (bus.req_waitrequest[2] && cycles < 10) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        n_vec++;
        if (cycles != 1 || bus.master_write !== 1'b1 || bus.master_address !== 32'h120) begin
            n_bad++;
            $display("FAIL wr_latency: got cycles=%0d write=%b addr=%h, want cycles=1 write=1 addr=00000120",
                     cycles, bus.master_write, bus.master_address);
        end else begin
            $display("vec wr_latency: accepted after %0d cycle ok", cycles);
        end
        // After acceptance the port idles with the last address held.
        v = mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 2, 4'hF, 0);
        @(negedge clk);
        drive(v);
        #2;
        check_vec("wr_hold", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
